div_seq: RTL and testbench

DIV_SEQ -- requirements
Module: div_seq

---
 rtl/div_seq.sv | 92 +++++++++
 tb/tb_div_seq.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// Sequential unsigned divider: restoring division, one quotient bit per clock,
// MSB first, with a fixed WIDTH-cycle run phase and a one-cycle done pulse.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] dvd;     // dividend shifting out, quotient bits shifting in
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] prem;    // partial remainder, always < dvs between steps
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   shifted;
  logic             fits;
  logic [WIDTH-1:0] trial;

  // The shifted value needs WIDTH+1 bits; the difference always fits WIDTH.
  always_comb begin
    shifted = {prem, dvd[WIDTH-1]};
    fits    = shifted >= {1'b0, dvs};
    trial   = fits ? (shifted[WIDTH-1:0] - dvs) : shifted[WIDTH-1:0];
  end

  assign busy = (state == RUN);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      dvd         <= '0;
      dvs         <= '0;
      prem        <= '0;
      cnt         <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done  <= 1'b0;
          state <= IDLE;
          if (go) begin
            dvd  <= left;
            dvs  <= right;
            prem <= '0;
            cnt  <= '0;
            if (right == '0) begin
              state       <= DONE;
              done        <= 1'b1;
              div_by_zero <= 1'b1;
              quotient    <= '1;
              remainder   <= left;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          dvd  <= {dvd[WIDTH-2:0], fits};
          prem <= trial;
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state       <= DONE;
            done        <= 1'b1;
            div_by_zero <= 1'b0;
            quotient    <= {dvd[WIDTH-2:0], fits};
            remainder   <= trial;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed WIDTH=8 scenarios plus a randomized
// WIDTH=32 run, with expected results queued at issue and checked at done.
module tb_div_seq;

  typedef struct {
    logic [63:0] l;
    logic [63:0] r;
    logic [63:0] q;
    logic [63:0] rem;
    logic        dz;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        go8, go32;
  logic [7:0]  left8, right8, q8, r8;
  logic [31:0] left32, right32, q32, r32;
  logic        busy8, done8, dz8, busy32, done32, dz32;

  exp_t exp8_q[$];
  exp_t exp32_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   done_cnt8 = 0;

  always #5 clk = ~clk;

  div_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .go(go8), .left(left8), .right(right8),
    .busy(busy8), .done(done8), .quotient(q8), .remainder(r8), .div_by_zero(dz8)
  );

  div_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .go(go32), .left(left32), .right(right32),
    .busy(busy32), .done(done32), .quotient(q32), .remainder(r32), .div_by_zero(dz32)
  );

  always @(negedge clk) if (done8) done_cnt8++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive an accept request at the current negedge; optionally queue its result.
  task automatic start(input bit sel, input logic [63:0] l, input logic [63:0] r, input bit push);
    exp_t        e;
    logic [63:0] mask;
    mask  = sel ? 64'hFFFF_FFFF : 64'hFF;
    e.l   = l & mask;
    e.r   = r & mask;
    e.dz  = (e.r == 0);
    e.q   = e.dz ? mask : e.l / e.r;
    e.rem = e.dz ? e.l : e.l % e.r;
    e.lat = e.dz ? 1 : (sel ? 33 : 9);
    if (sel) begin
      left32 = e.l[31:0]; right32 = e.r[31:0]; go32 = 1'b1;
      if (push) exp32_q.push_back(e);
    end else begin
      left8 = e.l[7:0]; right8 = e.r[7:0]; go8 = 1'b1;
      if (push) exp8_q.push_back(e);
    end
  endtask

  // Step until done (bounded), checking busy each cycle, then pop and compare.
  // rk != 0 re-pulses go with rl/rr at cycle rk to probe run-phase immunity.
  task automatic finish(input bit sel, input int rk, input logic [7:0] rl, input logic [7:0] rr);
    exp_t        e;
    int          k = 0;
    bit          seen = 0;
    logic        b, d;
    logic [63:0] q, rem;
    if (sel) e = exp32_q.pop_front();
    else     e = exp8_q.pop_front();
    while (!seen && k < e.lat + 5) begin
      @(negedge clk);
      k++;
      b = sel ? busy32 : busy8;
      d = sel ? done32 : done8;
      check(sel ? "busy32" : "busy8", {63'd0, b}, {63'd0, k < e.lat});
      if (k == 1) begin
        if (sel) go32 = 1'b0; else go8 = 1'b0;
      end
      if (rk != 0 && k == rk) begin
        go8 = 1'b1; left8 = rl; right8 = rr;
      end
      if (rk != 0 && k == rk + 1) go8 = 1'b0;
      if (d) seen = 1;
    end
    q   = sel ? {32'd0, q32} : {56'd0, q8};
    rem = sel ? {32'd0, r32} : {56'd0, r8};
    check("done_seen", {63'd0, seen}, 64'd1);
    check("latency", 64'(k), 64'(e.lat));
    check("quotient", q, e.q);
    check("remainder", rem, e.rem);
    check("div_by_zero", {63'd0, sel ? dz32 : dz8}, {63'd0, e.dz});
    if (sel && e.r != 0) begin
      check("q*r+rem", q * e.r + rem, e.l);
      check("rem<r", {63'd0, rem < e.r}, 64'd1);
    end
  endtask

  initial begin
    int          dc;
    logic [63:0] l, r;
    reset = 1'b0;
    go8 = 1'b0; go32 = 1'b0;
    left8 = '0; right8 = '0; left32 = '0; right32 = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", {63'd0, busy8}, 64'd0);
    check("rst_done", {63'd0, done8}, 64'd0);
    check("rst_q", {56'd0, q8}, 64'd0);
    check("rst_r", {56'd0, r8}, 64'd0);
    check("rst_dz", {63'd0, dz8}, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // 100 / 7, then confirm results hold after done drops
    start(0, 100, 7, 1);
    finish(0, 0, 0, 0);
    @(negedge clk);
    check("hold_done", {63'd0, done8}, 64'd0);
    check("hold_q", {56'd0, q8}, 64'd14);
    check("hold_r", {56'd0, r8}, 64'd2);

    // divide by zero
    start(0, 200, 0, 1);
    finish(0, 0, 0, 0);
    @(negedge clk);

    // back-to-back: second go issued in the done cycle
    start(0, 255, 1, 1);
    finish(0, 0, 0, 0);
    start(0, 3, 9, 1);
    finish(0, 0, 0, 0);
    @(negedge clk);

    // go during RUN must be ignored
    start(0, 50, 5, 1);
    dc = done_cnt8;
    finish(0, 3, 8'd9, 8'd2);
    repeat (12) @(negedge clk);
    check("single_done", 64'(done_cnt8 - dc), 64'd1);

    // small cases: left < right, left == 0, left == right
    start(0, 3, 200, 1);   finish(0, 0, 0, 0);
    start(0, 0, 17, 1);    finish(0, 0, 0, 0);
    start(0, 255, 255, 1); finish(0, 0, 0, 0);
    @(negedge clk);

    // asynchronous reset in the middle of a division
    start(0, 100, 7, 0);
    @(negedge clk); go8 = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst_busy", {63'd0, busy8}, 64'd0);
    check("arst_done", {63'd0, done8}, 64'd0);
    check("arst_q", {56'd0, q8}, 64'd0);
    check("arst_r", {56'd0, r8}, 64'd0);
    check("arst_dz", {63'd0, dz8}, 64'd0);
    dc = done_cnt8;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (15) @(negedge clk);
    check("no_done_after_abort", 64'(done_cnt8), 64'(dc));
    start(0, 77, 8, 1);
    finish(0, 0, 0, 0);
    @(negedge clk);

    // WIDTH=32 randomized, issued back-to-back, with corner operands mixed in
    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 9))
        0: l = 64'd0;
        1: l = 64'd1;
        2: l = 64'hFFFF_FFFF;
        default: l = {32'd0, $urandom()};
      endcase
      case ($urandom_range(0, 19))
        0: r = 64'd0;
        1: r = 64'd1;
        2: r = 64'hFFFF_FFFF;
        3: r = 64'd2;
        4: r = {48'd0, 16'($urandom())};
        default: r = {32'd0, $urandom()};
      endcase
      start(1, l, r, 1);
      finish(1, 0, 0, 0);
    end
    @(negedge clk);
    check("busy32_idle", {63'd0, busy32}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
